uart_tx_fifo: RTL and testbench

Buffered 8N1 UART transmitter that sits directly downstream of the CPU's load/store stage. It accepts one byte per store to the UART address and queues it in a FIFO. The serializer drives the board `uart_tx` pin. The FIFO decouples the single-cycle store path from the slow serial line, so the CPU stalls only when it reads `full` back through the status path.

---
 rtl/uart_tx_fifo.sv | 186 ++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - buffered 8N1 UART transmitter with byte FIFO
//
// Parameters:
//   CLKS_PER_BIT  sysclk cycles per serial bit (2..65535)
//   FIFO_DEPTH    byte entries, power of two (2..256)
// Ports:
//   sysclk      clock, all logic on rising edge
//   cpu_resetn  asynchronous active-low reset
//   wr_en       one-cycle store strobe, queues wr_data
//   wr_data     byte to transmit
//   clr_ovf     one-cycle strobe, clears overflow
//   full        FIFO holds FIFO_DEPTH entries
//   empty       FIFO holds no entries
//   level       current entry count
//   busy        frame in progress or FIFO non-empty
//   overflow    sticky: a write was dropped because the FIFO was full
//   uart_tx     registered serial line, idle high

module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 1085,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          sysclk,
    input  logic                          cpu_resetn,
    input  logic                          wr_en,
    input  logic [7:0]                    wr_data,
    input  logic                          clr_ovf,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          busy,
    output logic                          overflow,
    output logic                          uart_tx
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;

    state_t        state, state_n;
    logic [15:0]   timer, timer_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shift, shift_n;
    logic          tx_q, tx_n;
    logic          timer_done;
    logic          count_nz;

    assign count_nz = (count != '0);
    assign full     = (count == CW'(FIFO_DEPTH));
    assign empty    = ~count_nz;
    assign level    = count;
    assign busy     = (state != IDLE) || count_nz;
    assign uart_tx  = tx_q;

    // Full is judged on the registered count, so a pop in the same cycle
    // does not make room for the incoming byte.
    assign push = wr_en && !full;

    always_ff @(posedge sysclk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge sysclk or negedge cpu_resetn) begin
        if (!cpu_resetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
            // A dropped write in the same cycle as clr_ovf keeps the flag set.
            if (wr_en && full) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    assign timer_done = (timer == BIT_LAST);

    always_ff @(posedge sysclk or negedge cpu_resetn) begin
        if (!cpu_resetn) begin
            state   <= IDLE;
            timer   <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx_q    <= 1'b1;
        end else begin
            state   <= state_n;
            timer   <= timer_n;
            bit_idx <= bit_idx_n;
            shift   <= shift_n;
            tx_q    <= tx_n;
        end
    end

    always_comb begin
        state_n   = state;
        timer_n   = timer + 16'd1;
        bit_idx_n = bit_idx;
        shift_n   = shift;
        pop       = 1'b0;

        case (state)
            IDLE: begin
                timer_n = '0;
                if (count_nz) begin
                    pop     = 1'b1;
                    shift_n = mem[rd_ptr];
                    state_n = START;
                end
            end
            START: begin
                if (timer_done) begin
                    timer_n   = '0;
                    bit_idx_n = '0;
                    state_n   = DATA;
                end
            end
            DATA: begin
                if (timer_done) begin
                    timer_n = '0;
                    shift_n = {1'b0, shift[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end
            end
            STOP: begin
                if (timer_done) begin
                    timer_n = '0;
                    // Chain straight into the next start bit when data waits.
                    if (count_nz) begin
                        pop     = 1'b1;
                        shift_n = mem[rd_ptr];
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                timer_n = '0;
            end
        endcase

        // The line register is loaded with the level of the upcoming cycle,
        // so the pin changes exactly on the state transition edge.
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_n[0];
            default: tx_n = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed self-checking bench for uart_tx_fifo

module tb_uart_tx_fifo;

    logic       sysclk = 1'b0;
    logic       cpu_resetn = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       clr_ovf = 1'b0;
    logic       full;
    logic       empty;
    logic [2:0] level;
    logic       busy;
    logic       overflow;
    logic       uart_tx;

    int n_assert = 0;
    int n_fail   = 0;

    uart_tx_fifo #(
        .CLKS_PER_BIT (4),
        .FIFO_DEPTH   (4)
    ) dut (
        .sysclk     (sysclk),
        .cpu_resetn (cpu_resetn),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .clr_ovf    (clr_ovf),
        .full       (full),
        .empty      (empty),
        .level      (level),
        .busy       (busy),
        .overflow   (overflow),
        .uart_tx    (uart_tx)
    );

    always #5 sysclk = ~sysclk;

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks frame cycles first..last (0 = first start-bit cycle, 39 = last
    // stop-bit cycle) against the 8N1 waveform of data, one tick per cycle.
    task automatic check_frame(input string tag, input logic [7:0] data,
                               input int first, input int last);
        logic exp_bit;
        for (int k = first; k <= last; k++) begin
            int b;
            b = k / 4;
            if (b == 0)      exp_bit = 1'b0;
            else if (b == 9) exp_bit = 1'b1;
            else             exp_bit = data[b-1];
            chk($sformatf("%s_c%0d", tag, k), {31'd0, uart_tx}, {31'd0, exp_bit});
            tick();
        end
    endtask

    // Writes n bytes on consecutive cycles from idle, then checks all frames.
    task automatic burst(input string tag, input logic [7:0] b0, input int n);
        int first;
        for (int i = 0; i < n; i++) begin
            wr_en   = 1'b1;
            wr_data = b0 + 8'(i);
            tick();
        end
        wr_en = 1'b0;
        if (n == 1) begin
            tick();
            first = 0;
        end else begin
            first = n - 2;
        end
        for (int i = 0; i < n; i++) begin
            check_frame($sformatf("%s_f%0d", tag, i), b0 + 8'(i), (i == 0) ? first : 0, 39);
        end
        chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_tx",    {31'd0, uart_tx},  32'd1);
        chk("rst_full",  {31'd0, full},     32'd0);
        chk("rst_empty", {31'd0, empty},    32'd1);
        chk("rst_level", {29'd0, level},    32'd0);
        chk("rst_busy",  {31'd0, busy},     32'd0);
        chk("rst_ovf",   {31'd0, overflow}, 32'd0);
        cpu_resetn = 1'b1;
        tick();
        tick();

        // Single byte 0x55
        wr_en   = 1'b1;
        wr_data = 8'h55;
        tick();
        wr_en = 1'b0;
        chk("single_level_N",  {29'd0, level},   32'd1);
        chk("single_empty_N",  {31'd0, empty},   32'd0);
        chk("single_busy_N",   {31'd0, busy},    32'd1);
        chk("single_tx_N",     {31'd0, uart_tx}, 32'd1);
        tick();
        chk("single_level_pop", {29'd0, level},  32'd0);
        check_frame("single", 8'h55, 0, 39);
        chk("single_busy_end", {31'd0, busy},    32'd0);
        chk("single_tx_end",   {31'd0, uart_tx}, 32'd1);
        tick();

        // Back-to-back 0x41 0x42 0x43
        wr_en = 1'b1;
        wr_data = 8'h41; tick();
        wr_data = 8'h42; tick();
        wr_data = 8'h43; tick();
        wr_en = 1'b0;
        chk("b2b_level2", {29'd0, level}, 32'd2);
        check_frame("b2b_41", 8'h41, 1, 39);
        chk("b2b_level1", {29'd0, level}, 32'd1);
        check_frame("b2b_42", 8'h42, 0, 39);
        chk("b2b_level0", {29'd0, level}, 32'd0);
        check_frame("b2b_43", 8'h43, 0, 39);
        chk("b2b_busy_end", {31'd0, busy}, 32'd0);
        tick();

        // Full / overflow: 0x01..0x06, sixth dropped
        for (int i = 0; i < 6; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'(i + 1);
            tick();
            if (i == 4) begin
                chk("ovf_level_peak", {29'd0, level}, 32'd4);
                chk("ovf_full_peak",  {31'd0, full},  32'd1);
                chk("ovf_not_yet",    {31'd0, overflow}, 32'd0);
            end
        end
        wr_en = 1'b0;
        chk("ovf_set",       {31'd0, overflow}, 32'd1);
        chk("ovf_level_hold", {29'd0, level},   32'd4);
        clr_ovf = 1'b1;
        check_frame("ovf_01", 8'h01, 4, 4);
        clr_ovf = 1'b0;
        chk("ovf_cleared", {31'd0, overflow}, 32'd0);
        check_frame("ovf_01", 8'h01, 5, 38);
        // Write while full at the STOP-expiry pop edge; clear in same cycle loses
        wr_en   = 1'b1;
        wr_data = 8'hEE;
        clr_ovf = 1'b1;
        check_frame("ovf_01", 8'h01, 39, 39);
        wr_en   = 1'b0;
        clr_ovf = 1'b0;
        chk("popfull_level", {29'd0, level},    32'd3);
        chk("popfull_ovf",   {31'd0, overflow}, 32'd1);
        chk("popfull_full",  {31'd0, full},     32'd0);
        check_frame("ovf_02", 8'h02, 0, 39);
        check_frame("ovf_03", 8'h03, 0, 39);
        check_frame("ovf_04", 8'h04, 0, 39);
        check_frame("ovf_05", 8'h05, 0, 39);
        chk("ovf_busy_end",  {31'd0, busy},  32'd0);
        chk("ovf_level_end", {29'd0, level}, 32'd0);
        chk("ovf_tx_end",    {31'd0, uart_tx}, 32'd1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("ovf_clr_end", {31'd0, overflow}, 32'd0);
        tick();

        // Write at a pop edge with level 2: level unchanged
        wr_en = 1'b1;
        wr_data = 8'hA0; tick();
        wr_data = 8'hA1; tick();
        wr_data = 8'hA2; tick();
        wr_en = 1'b0;
        chk("wp_level_pre", {29'd0, level}, 32'd2);
        check_frame("wp_a0", 8'hA0, 1, 38);
        wr_en   = 1'b1;
        wr_data = 8'hA3;
        check_frame("wp_a0", 8'hA0, 39, 39);
        wr_en = 1'b0;
        chk("wp_level_post", {29'd0, level},    32'd2);
        chk("wp_ovf",        {31'd0, overflow}, 32'd0);
        check_frame("wp_a1", 8'hA1, 0, 39);
        check_frame("wp_a2", 8'hA2, 0, 39);
        check_frame("wp_a3", 8'hA3, 0, 39);
        chk("wp_busy_end", {31'd0, busy}, 32'd0);
        tick();

        // Reset mid-frame during DATA bit 3 of 0x00 with two bytes queued
        wr_en = 1'b1;
        wr_data = 8'h00; tick();
        wr_data = 8'h11; tick();
        wr_data = 8'h22; tick();
        wr_en = 1'b0;
        chk("rmf_level_pre", {29'd0, level}, 32'd2);
        check_frame("rmf_00", 8'h00, 1, 17);
        cpu_resetn = 1'b0;
        #1;
        chk("rmf_tx",    {31'd0, uart_tx}, 32'd1);
        chk("rmf_level", {29'd0, level},   32'd0);
        chk("rmf_busy",  {31'd0, busy},    32'd0);
        chk("rmf_empty", {31'd0, empty},   32'd1);
        tick();
        tick();
        cpu_resetn = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            chk($sformatf("rmf_idle_%0d", i), {31'd0, uart_tx}, 32'd1);
        end
        chk("rmf_busy_after", {31'd0, busy},  32'd0);
        chk("rmf_level_after", {29'd0, level}, 32'd0);

        // Wrap-around: 0x10..0x19 in batches of 3
        burst("wrap_a", 8'h10, 3);
        tick();
        burst("wrap_b", 8'h13, 3);
        tick();
        burst("wrap_c", 8'h16, 3);
        tick();
        burst("wrap_d", 8'h19, 1);
        chk("wrap_level_end", {29'd0, level}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
